// File: rtl/hpau_pkg.sv
// Shared definitions for the HP-AU multi-precision add/sub sequencer.
package hpau_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_NWORDS = 4;

  // A single-limb configuration still needs a 1-bit index register.
  function automatic int unsigned idx_bits(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned IDX_W = idx_bits(DEF_NWORDS);

endpackage

// File: rtl/limb_addc.sv
// One limb of add/subtract with explicit carry-in; sub inverts b, cin supplies the +1.
module limb_addc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  always_comb begin
    b_eff = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    s     = sum[WIDTH-1:0];
    cout  = sum[WIDTH];
  end

endmodule

// File: rtl/mp_addsub_ctrl.sv
// Multi-precision add/subtract sequencer: one limb per clock through a shared
// limb adder, carry/borrow chained in a register, flags captured on the last limb.
module mp_addsub_ctrl
  import hpau_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NWORDS = DEF_NWORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sub,
  input  logic [WIDTH*NWORDS-1:0]  a,
  input  logic [WIDTH*NWORDS-1:0]  b,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH*NWORDS-1:0]  result,
  output logic                     cout,
  output logic                     zero,
  output logic                     ovf
);

  localparam int unsigned N    = WIDTH * NWORDS;
  localparam int unsigned IW   = idx_bits(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  state_e state_q, state_d;

  logic [N-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
  logic             sub_q, sub_d, carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
  logic             accept;
  logic [WIDTH-1:0] a_limb, b_limb, s_limb;
  logic             c_limb;

  // Start is ignored while limbs are in flight.
  assign accept = start && (state_q != ST_RUN);

  always_comb begin
    a_limb = a_q[int'(idx_q) * WIDTH +: WIDTH];
    b_limb = b_q[int'(idx_q) * WIDTH +: WIDTH];
  end

  limb_addc #(
    .WIDTH (WIDTH)
  ) u_limb (
    .a    (a_limb),
    .b    (b_limb),
    .sub  (sub_q),
    .cin  (carry_q),
    .s    (s_limb),
    .cout (c_limb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (idx_q == LAST) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    if (accept) begin
      // Previous result and flags stay visible until the first limb write.
      a_d     = a;
      b_d     = b;
      sub_d   = sub;
      idx_d   = '0;
      carry_d = sub;
    end else if (state_q == ST_RUN) begin
      result_d[int'(idx_q) * WIDTH +: WIDTH] = s_limb;
      carry_d = c_limb;
      idx_d   = idx_q + 1'b1;
      if (idx_q == LAST) begin
        cout_d = c_limb;
        zero_d = (result_d == '0);
        ovf_d  = (a_q[N-1] == (sub_q ? ~b_q[N-1] : b_q[N-1])) &&
                 (result_d[N-1] != a_q[N-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule
